// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue controller feeding a combinational MIPS ALU
// Decodes one request, holds ALU inputs for EXEC_CYCLES, then returns the captured result.
module alu_issue_ctrl #(
    parameter int WIDTH       = 16,
    parameter int EXEC_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_opcode,
    input  logic [5:0]       req_funct,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [WIDTH-1:0] req_imm,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_taken,
    output logic             rsp_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam int CNT_W = (EXEC_CYCLES < 2) ? 1 : $clog2(EXEC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             is_beq;
    logic             is_bne;

    logic [2:0]       dec_op;
    logic             dec_use_imm;
    logic             dec_err;
    logic             dec_beq;
    logic             dec_bne;
    logic             result_zero;

    always_comb begin
        dec_op      = OP_AND;
        dec_use_imm = 1'b0;
        dec_err     = 1'b0;
        dec_beq     = 1'b0;
        dec_bne     = 1'b0;
        case (req_opcode)
            6'h00: begin
                case (req_funct)
                    6'h20:   dec_op = OP_ADD;
                    6'h22:   dec_op = OP_SUB;
                    6'h24:   dec_op = OP_AND;
                    6'h25:   dec_op = OP_OR;
                    6'h2A:   dec_op = OP_SLT;
                    default: dec_err = 1'b1;
                endcase
            end
            6'h08: begin dec_op = OP_ADD; dec_use_imm = 1'b1; end
            6'h0C: begin dec_op = OP_AND; dec_use_imm = 1'b1; end
            6'h0D: begin dec_op = OP_OR;  dec_use_imm = 1'b1; end
            6'h0A: begin dec_op = OP_SLT; dec_use_imm = 1'b1; end
            6'h04: begin dec_op = OP_SUB; dec_beq = 1'b1; end
            6'h05: begin dec_op = OP_SUB; dec_bne = 1'b1; end
            default: dec_err = 1'b1;
        endcase
    end

    assign result_zero = (alu_result == '0);
    assign req_ready   = (state == ST_IDLE);
    assign rsp_valid   = (state == ST_RESP);

    // Error requests skip EXEC and leave alu_* untouched so the ALU inputs never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            is_beq     <= 1'b0;
            is_bne     <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_taken  <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (dec_err) begin
                            rsp_result <= '0;
                            rsp_zero   <= 1'b0;
                            rsp_taken  <= 1'b0;
                            rsp_err    <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            alu_op <= dec_op;
                            alu_a  <= req_a;
                            alu_b  <= dec_use_imm ? req_imm : req_b;
                            is_beq <= dec_beq;
                            is_bne <= dec_bne;
                            cnt    <= CNT_LOAD;
                            state  <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        rsp_result <= alu_result;
                        rsp_zero   <= result_zero;
                        rsp_taken  <= (is_beq & result_zero) | (is_bne & ~result_zero);
                        rsp_err    <= 1'b0;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    localparam int W = 16;
    localparam int E = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [5:0]    req_opcode = '0;
    logic [5:0]    req_funct = '0;
    logic [W-1:0]  req_a = '0;
    logic [W-1:0]  req_b = '0;
    logic [W-1:0]  req_imm = '0;
    logic [2:0]    alu_op;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [W-1:0]  alu_result;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_result;
    logic          rsp_zero;
    logic          rsp_taken;
    logic          rsp_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(W), .EXEC_CYCLES(E)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_funct(req_funct),
        .req_a(req_a), .req_b(req_b), .req_imm(req_imm),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_taken(rsp_taken), .rsp_err(rsp_err)
    );

    // Reference 16-bit MIPS ALU
    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010: alu_result = alu_a + alu_b;
            3'b110: alu_result = alu_a - alu_b;
            3'b111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 16'd1 : 16'd0;
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic [5:0]   opcode;
        logic [5:0]   funct;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] imm;
        logic [2:0]   exp_op;
        logic [W-1:0] exp_alu_b;
        logic [W-1:0] exp_result;
        logic         exp_zero;
        logic         exp_taken;
        logic         exp_err;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [5:0] opc, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm);
        @(negedge clk);
        req_opcode = opc; req_funct = fn; req_a = a; req_b = b; req_imm = imm;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Called at the negedge after the accept edge; returns edges elapsed until rsp_valid.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [2:0]   prev_op;
        logic [W-1:0] prev_a;
        logic [W-1:0] prev_b;
        int           lat;
        prev_op = alu_op; prev_a = alu_a; prev_b = alu_b;
        chk($sformatf("v%0d_req_ready", idx), {31'd0, req_ready}, 32'd1);
        send(v.opcode, v.funct, v.a, v.b, v.imm);
        if (v.exp_err) begin
            chk($sformatf("v%0d_alu_op_kept", idx), {29'd0, alu_op}, {29'd0, prev_op});
            chk($sformatf("v%0d_alu_a_kept", idx), {16'd0, alu_a}, {16'd0, prev_a});
            chk($sformatf("v%0d_alu_b_kept", idx), {16'd0, alu_b}, {16'd0, prev_b});
        end else begin
            chk($sformatf("v%0d_alu_op", idx), {29'd0, alu_op}, {29'd0, v.exp_op});
            chk($sformatf("v%0d_alu_a", idx), {16'd0, alu_a}, {16'd0, v.a});
            chk($sformatf("v%0d_alu_b", idx), {16'd0, alu_b}, {16'd0, v.exp_alu_b});
        end
        wait_rsp(lat);
        chk($sformatf("v%0d_latency", idx), lat, v.exp_err ? 32'd0 : E);
        chk($sformatf("v%0d_result", idx), {16'd0, rsp_result}, {16'd0, v.exp_result});
        chk($sformatf("v%0d_zero", idx), {31'd0, rsp_zero}, {31'd0, v.exp_zero});
        chk($sformatf("v%0d_taken", idx), {31'd0, rsp_taken}, {31'd0, v.exp_taken});
        chk($sformatf("v%0d_err", idx), {31'd0, rsp_err}, {31'd0, v.exp_err});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_rsp_drop", idx), {31'd0, rsp_valid}, 32'd0);
        chk($sformatf("v%0d_idle", idx), {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        //          opc    fn     a         b         imm       op      alu_b     result   z     t     e
        vecs[0]  = '{6'h00, 6'h20, 16'd5,    16'd1,    16'd0,    3'b010, 16'd1,    16'd6,    1'b0, 1'b0, 1'b0};
        vecs[1]  = '{6'h00, 6'h22, 16'd15,   16'd1,    16'd0,    3'b110, 16'd1,    16'd14,   1'b0, 1'b0, 1'b0};
        vecs[2]  = '{6'h00, 6'h2A, 16'd14,   16'd15,   16'd0,    3'b111, 16'd15,   16'd1,    1'b0, 1'b0, 1'b0};
        vecs[3]  = '{6'h00, 6'h2A, 16'd5,    16'd1,    16'd0,    3'b111, 16'd1,    16'd0,    1'b1, 1'b0, 1'b0};
        vecs[4]  = '{6'h00, 6'h24, 16'hF0F0, 16'hFF00, 16'd0,    3'b000, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{6'h00, 6'h25, 16'h00F0, 16'h0F00, 16'd0,    3'b001, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{6'h08, 6'h00, 16'hFFFF, 16'h1234, 16'd1,    3'b010, 16'd1,    16'd0,    1'b1, 1'b0, 1'b0};
        vecs[7]  = '{6'h0C, 6'h00, 16'h1234, 16'h5555, 16'h00FF, 3'b000, 16'h00FF, 16'h0034, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{6'h0D, 6'h00, 16'h1200, 16'hAAAA, 16'h0034, 3'b001, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{6'h0A, 6'h00, 16'h8000, 16'd0,    16'd1,    3'b111, 16'd1,    16'd1,    1'b0, 1'b0, 1'b0};
        vecs[10] = '{6'h04, 6'h00, 16'h1234, 16'h1234, 16'hFFFF, 3'b110, 16'h1234, 16'd0,    1'b1, 1'b1, 1'b0};
        vecs[11] = '{6'h05, 6'h00, 16'h1234, 16'h1234, 16'hFFFF, 3'b110, 16'h1234, 16'd0,    1'b1, 1'b0, 1'b0};
        vecs[12] = '{6'h05, 6'h00, 16'd3,    16'd1,    16'd0,    3'b110, 16'd1,    16'd2,    1'b0, 1'b1, 1'b0};
        vecs[13] = '{6'h3F, 6'h00, 16'h7777, 16'h8888, 16'h9999, 3'b000, 16'd0,    16'd0,    1'b0, 1'b0, 1'b1};
        vecs[14] = '{6'h00, 6'h21, 16'h0001, 16'h0002, 16'd0,    3'b000, 16'd0,    16'd0,    1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
        chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
        chk("rst_rsp_fields", {28'd0, rsp_result == '0, rsp_zero, rsp_taken, rsp_err}, 32'h8);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Backpressure: response held, competing request ignored
        send(6'h00, 6'h20, 16'd5, 16'd1, 16'd0);
        wait_rsp(lat);
        chk("bp_latency", lat, E);
        req_opcode = 6'h00; req_funct = 6'h22; req_a = 16'd9; req_b = 16'd9;
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_valid_%0d", k), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("bp_result_%0d", k), {16'd0, rsp_result}, 32'd6);
            chk($sformatf("bp_req_ready_%0d", k), {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_rsp_drop", {31'd0, rsp_valid}, 32'd0);
        chk("bp_idle", {31'd0, req_ready}, 32'd1);
        chk("bp_alu_op_kept", {29'd0, alu_op}, 32'h2);
        chk("bp_alu_a_kept", {16'd0, alu_a}, 32'd5);

        // Reset in the middle of EXEC
        send(6'h00, 6'h22, 16'd15, 16'd1, 16'd0);
        chk("mid_in_exec", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_alu_op", {29'd0, alu_op}, 32'd0);
        chk("mid_alu_a", {16'd0, alu_a}, 32'd0);
        chk("mid_alu_b", {16'd0, alu_b}, 32'd0);
        chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rsp_fields", {16'd0, rsp_result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_req_ready", {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("mid_no_rsp_%0d", k), {31'd0, rsp_valid}, 32'd0);
        end

        // One more request after reset still works
        run_vec(vecs[0], 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
